// File: rtl/cmprs_rdf_feeder.sv
// Packs 12-bit raw samples in pairs into 32-bit words for the compressor read port.
// Optional macro CMPRS_RDF_SAT_EN: clamp samples above 4095 instead of truncating.
module cmprs_rdf_feeder #(
    parameter int X_LEN = 11,
    parameter int Y_LEN = 6,
    parameter int Z_LEN = 8
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [X_LEN-1:0]  X_max,
    input  logic [Y_LEN-1:0]  Y_max,
    input  logic [Z_LEN-1:0]  Z_max,
    input  logic              src_valid,
    input  logic [15:0]       src_data,
    output logic              src_ready,
    output logic              cmprs_rdf_data_valid,
    output logic [31:0]       cmprs_rdf_rd_data,
    input  logic              cmprs_rdf_data_ready,
    output logic              cmprs_rdf_data_end,
    output logic              busy
);

    localparam int LW = X_LEN + Z_LEN;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state;
    logic [LW-1:0]    line_last;
    logic [LW-1:0]    samp_cnt;
    logic [Y_LEN-1:0] y_max_r;
    logic [Y_LEN-1:0] line_cnt;
    logic [11:0]      pair_lo;
    logic [32:0]      fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;

    logic [LW:0]      x_ext, z_ext, prod, prod_m1;
    logic [11:0]      sample;
    logic             accept, line_end, frame_end, push, pop;
    logic [32:0]      push_word;

`ifdef CMPRS_RDF_SAT_EN
    assign sample = (src_data > 16'd4095) ? 12'hFFF : src_data[11:0];
`else
    logic unused_src_hi;
    assign unused_src_hi = ^src_data[15:12];
    assign sample        = src_data[11:0];
`endif

    // Last in-line sample index: (X+1)*(Z+1)-1 always fits LW bits.
    always_comb begin
        x_ext   = (LW+1)'(X_max) + (LW+1)'(1);
        z_ext   = (LW+1)'(Z_max) + (LW+1)'(1);
        prod    = x_ext * z_ext;
        prod_m1 = prod - (LW+1)'(1);
    end

    assign src_ready = (state == RUN) && (fifo_cnt != 2'd2);
    assign accept    = src_valid && src_ready;
    assign line_end  = (samp_cnt == line_last);
    assign frame_end = line_end && (line_cnt == y_max_r);
    assign push      = accept && (samp_cnt[0] || line_end);
    assign pop       = cmprs_rdf_data_valid && cmprs_rdf_data_ready;

    // An odd-length line closes its last word with a zero high field.
    always_comb begin
        if (samp_cnt[0])
            push_word = {frame_end, 4'd0, sample, 4'd0, pair_lo};
        else
            push_word = {frame_end, 16'd0, 4'd0, sample};
    end

    assign cmprs_rdf_data_valid = (fifo_cnt != 2'd0);
    assign cmprs_rdf_rd_data    = fifo_mem[rd_ptr][31:0];
    assign cmprs_rdf_data_end   = fifo_mem[rd_ptr][32] && cmprs_rdf_data_valid;
    assign busy                 = (state != IDLE);

    // NOTE: the two FIFO entries are reset too, so rd_data reads 0 after reset.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            line_last   <= '0;
            samp_cnt    <= '0;
            y_max_r     <= '0;
            line_cnt    <= '0;
            pair_lo     <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        line_last <= prod_m1[LW-1:0];
                        y_max_r   <= Y_max;
                        samp_cnt  <= '0;
                        line_cnt  <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!samp_cnt[0])
                            pair_lo <= sample;
                        if (line_end) begin
                            samp_cnt <= '0;
                            if (frame_end) begin
                                line_cnt <= '0;
                                state    <= FLUSH;
                            end else begin
                                line_cnt <= line_cnt + 1'b1;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (fifo_cnt == 2'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_cmprs_rdf_feeder.sv
// Directed bench for cmprs_rdf_feeder: a frame-level word model plus per-cycle
// handshake checks; honours CMPRS_RDF_SAT_EN for the expected sample fields.
module tb_cmprs_rdf_feeder;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic        cfg_en;
    logic [10:0] X_max;
    logic [5:0]  Y_max;
    logic [7:0]  Z_max;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_ready;
    logic        cmprs_rdf_data_valid;
    logic [31:0] cmprs_rdf_rd_data;
    logic        cmprs_rdf_data_ready;
    logic        cmprs_rdf_data_end;
    logic        busy;

    always #5 sclk = ~sclk;

    cmprs_rdf_feeder dut (
        .sclk                 (sclk),
        .rst_n                (rst_n),
        .cfg_en               (cfg_en),
        .X_max                (X_max),
        .Y_max                (Y_max),
        .Z_max                (Z_max),
        .src_valid            (src_valid),
        .src_data             (src_data),
        .src_ready            (src_ready),
        .cmprs_rdf_data_valid (cmprs_rdf_data_valid),
        .cmprs_rdf_rd_data    (cmprs_rdf_rd_data),
        .cmprs_rdf_data_ready (cmprs_rdf_data_ready),
        .cmprs_rdf_data_end   (cmprs_rdf_data_end),
        .busy                 (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] log_data[$];
    logic        log_end[$];
    logic [15:0] samp[64];
    int          checks = 0;
    int          errors = 0;
    int          pushed = 0;
    int          popped = 0;
    int          frame_len = 1;
    bit          saw_block = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] field(input logic [15:0] s);
`ifdef CMPRS_RDF_SAT_EN
        return (s > 16'd4095) ? 12'hFFF : s[11:0];
`else
        return s[11:0];
`endif
    endfunction

    // Whole-frame expectation: pairs restart per line, odd tail gets high=0.
    function automatic void build_model(input int len, input int nlines);
        for (int ln = 0; ln < nlines; ln++) begin
            for (int i = 0; i < len; i += 2) begin
                word_t w;
                logic [11:0] lo, hi;
                lo     = field(samp[ln*len + i]);
                hi     = (i + 1 < len) ? field(samp[ln*len + i + 1]) : 12'd0;
                w.data = {4'd0, hi, 4'd0, lo};
                w.last = (ln == nlines - 1) && (i + 2 >= len);
                exp_q.push_back(w);
            end
        end
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic end_at(input int i);
        return (i < log_end.size()) ? log_end[i] : 1'bx;
    endfunction

    // Per-cycle output checking against the model and the occupancy bookkeeping.
    logic        prev_hold = 1'b0;
    logic        prev_full = 1'b0;
    logic [31:0] prev_data;
    logic        prev_end;
    always @(negedge sclk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_full = 1'b0;
            exp_q.delete();
        end else begin
            int outstanding;
            outstanding = pushed - popped;
            check("valid_vs_occupancy", cmprs_rdf_data_valid, outstanding != 0);
            if (cmprs_rdf_data_end && !cmprs_rdf_data_valid)
                check("end_without_valid", cmprs_rdf_data_end, 1'b0);
            if (prev_hold) begin
                check("hold_data", cmprs_rdf_rd_data, prev_data);
                check("hold_end", cmprs_rdf_data_end, prev_end);
            end
            if (outstanding >= 2 && prev_full)
                check("ready_when_full", src_ready, 1'b0);
            if (outstanding >= 2 && !src_ready)
                saw_block = 1'b1;
            prev_full = (outstanding >= 2);
            prev_hold = cmprs_rdf_data_valid && !cmprs_rdf_data_ready;
            prev_data = cmprs_rdf_rd_data;
            prev_end  = cmprs_rdf_data_end;
            if (cmprs_rdf_data_valid && cmprs_rdf_data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", cmprs_rdf_rd_data);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("word_data", cmprs_rdf_rd_data, w.data);
                    check("word_end", cmprs_rdf_data_end, w.last);
                end
                log_data.push_back(cmprs_rdf_rd_data);
                log_end.push_back(cmprs_rdf_data_end);
                popped++;
            end
        end
    end

    task automatic start_frame(input int xm, input int ym, input int zm);
        frame_len = (xm + 1) * (zm + 1);
        build_model(frame_len, ym + 1);
        X_max  = 11'(xm);
        Y_max  = 6'(ym);
        Z_max  = 8'(zm);
        cfg_en = 1'b1;
        @(posedge sclk); #1;
        cfg_en = 1'b0;
    endtask

    task automatic send_samples(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 500) begin
            logic r;
            src_valid = 1'b1;
            src_data  = samp[k];
            @(negedge sclk);
            r = src_ready;
            @(posedge sclk);
            if (r) begin
                int idx;
                idx = k % frame_len;
                if (idx % 2 == 1 || idx == frame_len - 1)
                    pushed++;
                k++;
            end
            guard++;
            #1;
        end
        src_valid = 1'b0;
        if (k < n) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got %0d samples accepted, expected %0d", k, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (guard < 100 && (busy || exp_q.size() != 0)) begin
            @(negedge sclk);
            guard++;
        end
        check({name, "_busy_cleared"}, busy, 1'b0);
        check({name, "_all_words_seen"}, exp_q.size(), 0);
        check({name, "_ready_idle"}, src_ready, 1'b0);
        @(posedge sclk); #1;
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        cfg_en = 1'b0;
        X_max = '0;
        Y_max = '0;
        Z_max = '0;
        src_valid = 1'b0;
        src_data = '0;
        cmprs_rdf_data_ready = 1'b1;
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        check("rst_src_ready", src_ready, 1'b0);
        check("rst_valid", cmprs_rdf_data_valid, 1'b0);
        check("rst_data", cmprs_rdf_rd_data, 32'h0);
        check("rst_end", cmprs_rdf_data_end, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge sclk); #1;
        rst_n = 1'b1;
        @(posedge sclk); #1;

        // 2x2 single line, ready always high
        base = log_data.size();
        samp[0] = 16'd1; samp[1] = 16'd2; samp[2] = 16'd3; samp[3] = 16'd4;
        start_frame(1, 0, 1);
        check("s1_busy", busy, 1'b1);
        send_samples(4);
        wait_idle("s1");
        check("s1_word0", log_at(base), 32'h0002_0001);
        check("s1_word1", log_at(base + 1), 32'h0004_0003);
        check("s1_end0", end_at(base), 1'b0);
        check("s1_end1", end_at(base + 1), 1'b1);

        // odd line length L=3, two lines
        base = log_data.size();
        samp[0] = 16'd10; samp[1] = 16'd11; samp[2] = 16'd12;
        samp[3] = 16'd20; samp[4] = 16'd21; samp[5] = 16'd22;
        start_frame(0, 1, 2);
        send_samples(6);
        wait_idle("s2");
        check("s2_word0", log_at(base), 32'h000B_000A);
        check("s2_word1", log_at(base + 1), 32'h0000_000C);
        check("s2_word2", log_at(base + 2), 32'h0015_0014);
        check("s2_word3", log_at(base + 3), 32'h0000_0016);
        check("s2_end1", end_at(base + 1), 1'b0);
        check("s2_end3", end_at(base + 3), 1'b1);

        // downstream stalls for 10 cycles mid-frame
        for (int i = 0; i < 16; i++) samp[i] = 16'(16'h0100 + i * 7);
        saw_block = 1'b0;
        start_frame(3, 1, 1);
        fork
            send_samples(16);
            begin
                repeat (5) @(posedge sclk);
                #1 cmprs_rdf_data_ready = 1'b0;
                repeat (10) @(posedge sclk);
                #1 cmprs_rdf_data_ready = 1'b1;
            end
        join
        wait_idle("s3");
        check("s3_backpressure_seen", saw_block, 1'b1);

        // out-of-range samples
        base = log_data.size();
        samp[0] = 16'hFFFF; samp[1] = 16'h1005; samp[2] = 16'h0FFF; samp[3] = 16'h0000;
        start_frame(1, 0, 1);
        send_samples(4);
        wait_idle("s4");
`ifdef CMPRS_RDF_SAT_EN
        check("s4_word0", log_at(base), 32'h0FFF_0FFF);
`else
        check("s4_word0", log_at(base), 32'h0005_0FFF);
`endif
        check("s4_word1", log_at(base + 1), 32'h0000_0FFF);

        // cfg_en while running is ignored
        base = log_data.size();
        samp[0] = 16'h11; samp[1] = 16'h22; samp[2] = 16'h33; samp[3] = 16'h44;
        start_frame(1, 1, 0);
        fork
            send_samples(4);
            begin
                @(posedge sclk); #1;
                cfg_en = 1'b1;
                X_max  = 11'd5;
                @(posedge sclk); #1;
                cfg_en = 1'b0;
                X_max  = 11'd1;
            end
        join
        wait_idle("s5");
        check("s5_word0", log_at(base), 32'h0022_0011);
        check("s5_word1", log_at(base + 1), 32'h0044_0033);
        check("s5_end1", end_at(base + 1), 1'b1);

        // reset mid-frame, then a fresh frame
        for (int i = 0; i < 16; i++) samp[i] = 16'(16'h0200 + i);
        start_frame(3, 3, 0);
        send_samples(5);
        rst_n = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
        check("s6_rst_src_ready", src_ready, 1'b0);
        check("s6_rst_valid", cmprs_rdf_data_valid, 1'b0);
        check("s6_rst_data", cmprs_rdf_rd_data, 32'h0);
        check("s6_rst_end", cmprs_rdf_data_end, 1'b0);
        check("s6_rst_busy", busy, 1'b0);
        pushed = popped;
        @(posedge sclk); #1;
        rst_n = 1'b1;
        @(posedge sclk); #1;
        base = log_data.size();
        samp[0] = 16'd7; samp[1] = 16'd8; samp[2] = 16'd9; samp[3] = 16'd10;
        start_frame(1, 0, 1);
        send_samples(4);
        wait_idle("s6");
        check("s6_word0", log_at(base), 32'h0008_0007);
        check("s6_word1", log_at(base + 1), 32'h000A_0009);
        check("s6_word_count", log_data.size() - base, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
